// File: rtl/ir_src_ctrl.sv
// ir_src_ctrl: EX-stage instruction-source select with BNE redirect and NOP flush sequencing
module ir_src_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_bne,
  input  logic             alu_zero,
  output logic [1:0]       ir_src_alu,
  output logic             pc_src,
  output logic             flushing,
  output logic [CNT_W-1:0] taken_cnt
);
  typedef enum logic [1:0] {PASS, REDIRECT, FLUSH} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic taken, inc;
  assign taken = ex_valid & ex_is_bne & ~alu_zero;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PASS;
      cnt <= '0;
      taken_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (inc && !(&taken_cnt)) taken_cnt <= taken_cnt + 1'b1;
    end
  end
  // Branches seen outside PASS belong to squashed instructions and are ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    inc = 1'b0;
    if (!stall) begin
      case (state)
        PASS: if (taken) begin
          state_nxt = REDIRECT;
          inc = 1'b1;
        end
        REDIRECT: if (FLUSH_CYCLES == 0) state_nxt = PASS;
        else begin
          cnt_nxt = 4'(FLUSH_CYCLES - 1);
          state_nxt = FLUSH;
        end
        FLUSH: if (cnt == 4'd0) state_nxt = PASS;
        else cnt_nxt = cnt - 4'd1;
        default: state_nxt = PASS;
      endcase
    end
  end
  assign ir_src_alu = (state == REDIRECT) ? 2'b10 : (state == FLUSH) ? 2'b01 : 2'b00;
  assign pc_src = (state == REDIRECT);
  assign flushing = (state != PASS);
endmodule
